sobel: RTL and testbench
========================

Name: sobel

Overview:
- Streaming 3x3 Sobel edge detector for 8-bit grayscale video.
- Sits after the gray-conversion stage; consumes one pixel per accepted valid beat.
- Emits one edge-magnitude pixel per accepted input pixel, with fixed latency.
- Uses two internal line buffers plus a 3x3 window register array.

Parameters:
- IMG_WIDTH, 640, maximum pixels per line; sets line-buffer depth and column-counter width.
- SAT_MAX, 255, output saturation ceiling.

Ports:
- clk  input  1  single system clock; all logic is on the rising edge.
- rst_n  input  1  reset: one clock; reset is synchronous and active-high (asserted level 1 resets; port name kept for codebase compatibility).
- gray_valid  input  1  pixel strobe; every rising edge with gray_valid=1 accepts gray_data as one pixel.
- gray_data  input  8  grayscale pixel, unsigned.
- hsync  input  1  line sync; high between lines, low during the active line.
- vsync  input  1  frame sync; active-low frame-start pulse, high otherwise.
- sobel_valid  output  1  one-cycle strobe per accepted input pixel.
- sobel_data  output  8  edge magnitude, unsigned, saturated.

Behaviour:
- Reset (rst_n=1 at a clock edge):
  - sobel_valid=0, sobel_data=0.
  - Row/column counters, window registers and pipeline registers cleared.
  - Line-buffer RAM is not cleared; border masking covers stale contents.
  - Reset mid-frame abandons the frame; the next frame starts at the next vsync low.
- Frame start: vsync=0 at an edge clears the row counter, column counter and sync-edge tracking; pixels accepted in that same cycle are ignored.
- Line start: hsync=1 at an edge clears the column counter. On the hsync 0->1 transition, the row counter increments if at least one pixel was accepted on the line.
- Pixel accept, when gray_valid=1, vsync=1 and hsync=0:
  - Read the column's value from line buffers LB1 (row r-1) and LB2 (row r-2).
  - Write LB2<=LB1 and LB1<=gray_data at the column.
  - Shift the window left; the new right column is {LB2, LB1, gray_data}.
  - Increment the column counter.
  - At column >= IMG_WIDTH the pixel is still accepted and output, but not written to the line buffers, and its output is 0.
- Window: p[i][j], with i = row (0 oldest) and j = column (0 oldest). The output is the magnitude centred on input position (r-1, c-1).
- Arithmetic, 11-bit signed minimum:
  - Gx = (p02 + 2*p12 + p22) - (p00 + 2*p10 + p20).
  - Gy = (p20 + 2*p21 + p22) - (p00 + 2*p01 + p02).
  - mag = |Gx| + |Gy| (range 0..2040).
  - sobel_data = min(mag, SAT_MAX).
- Border masking: if the current row < 2 or the current column < 2, sobel_data = 0 (sobel_valid is still asserted).
- Pipeline and latency:
  - Pixel accepted at edge k -> stage 1 window update (k).
  - Stage 2: Gx/Gy registered (k+1).
  - Stage 3: saturated magnitude and valid registered (k+2).
  - sobel_valid/sobel_data are visible after edge k+2, before edge k+3, for exactly one cycle.
  - Back-to-back accepts give back-to-back outputs; throughput is 1 pixel/cycle.
  - Gaps in gray_valid propagate as gaps in sobel_valid. There is no backpressure.
- Simultaneous events:
  - vsync=0 has priority over hsync and over a pixel accept.
  - hsync=1 blocks a pixel accept.
  - Pipeline stages already in flight complete normally across sync events.
- sobel_data holds its last value when sobel_valid=0.

Test Plan:
- Reset: hold rst_n=1 for 5 cycles with gray_valid=1 -> sobel_valid=0, sobel_data=0 throughout; after release, the first accept yields sobel_valid exactly 3 edges later.
- Flat frame, 8x8 all 100 (vsync pulse, per-line hsync high then low, continuous gray_valid) -> 64 outputs, all 0.
- Vertical step edge, 8x8 with columns 0-3 = 0 and columns 4-7 = 255 -> rows>=2, window columns spanning the step output 255 (Gx=1020, saturated); flat interior and borders output 0.
- Horizontal ramp, pixel=10*col, 8x8 -> interior outputs 80 (Gx=80, Gy=0); rows 0-1 and columns 0-1 output 0.
- Vertical ramp, pixel=5*row, 8x8 -> interior outputs 40 (Gy=40); one sobel_valid per accepted pixel, counted 64.
- Gapped valid and mid-frame reset: gray_valid toggled 1/0 -> sobel_valid pattern equals the input pattern delayed 3 edges. Then assert reset mid-line, then a new vsync frame -> the first two rows output 0 and results match the flat/ramp golden values.

Source files
------------

// File: rtl/sobel.sv
// sobel: streaming 3x3 Sobel edge-magnitude filter for 8-bit gray video.
// Ports: clk, rst_n (sync, active-high), gray_valid/gray_data/hsync/vsync in, sobel_valid/sobel_data out.
module sobel #(
  parameter int IMG_WIDTH = 640,
  parameter int SAT_MAX   = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       gray_valid,
  input  logic [7:0] gray_data,
  input  logic       hsync,
  input  logic       vsync,
  output logic       sobel_valid,
  output logic [7:0] sobel_data
);

  localparam int CW = $clog2(IMG_WIDTH + 1);
  localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW = 12;

  localparam logic [CW-1:0] COL_LIM = CW'(IMG_WIDTH);
  localparam logic [10:0]   SAT11   = 11'(SAT_MAX);
  localparam logic [7:0]    SAT8    = 8'(SAT_MAX);

  typedef enum logic [1:0] {
    EV_IDLE,
    EV_FRAME,
    EV_LINE,
    EV_PIX
  } ev_e;

  typedef struct packed {
    logic vld;
    logic mask;
  } s1_t;

  typedef struct packed {
    logic               vld;
    logic               mask;
    logic signed [10:0] gx;
    logic signed [10:0] gy;
  } s2_t;

  ev_e           ev;
  logic          acc;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          hs_q;
  logic          line_pix;
  logic          in_range;
  logic [AW-1:0] addr;
  logic          mask_now;

  logic [7:0] lb1 [IMG_WIDTH];
  logic [7:0] lb2 [IMG_WIDTH];
  logic [7:0] lb1_rd;
  logic [7:0] lb2_rd;

  logic [7:0] win [3][3];
  s1_t        s1;
  s2_t        s2;

  logic [9:0]         gx_p;
  logic [9:0]         gx_n;
  logic [9:0]         gy_p;
  logic [9:0]         gy_n;
  logic signed [10:0] gx;
  logic signed [10:0] gy;
  logic [10:0]        mag;
  logic [7:0]         sat;

  // Frame sync outranks line sync, which outranks a pixel.
  always_comb begin
    ev = EV_IDLE;
    unique case (1'b1)
      !vsync:                        ev = EV_FRAME;
      vsync && hsync:                ev = EV_LINE;
      vsync && !hsync && gray_valid: ev = EV_PIX;
      default:                       ev = EV_IDLE;
    endcase
  end

  assign acc      = !rst_n && (ev == EV_PIX);
  assign in_range = (col < COL_LIM);
  assign addr     = in_range ? col[AW-1:0] : '0;
  assign lb1_rd   = lb1[addr];
  assign lb2_rd   = lb2[addr];

  // Overflow pixels beyond the line width are forced to zero too.
  assign mask_now = (row < RW'(2)) ||
                    (col < CW'(2)) ||
                    !in_range;

  // Row/column position tracking.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      col      <= '0;
      row      <= '0;
      hs_q     <= 1'b0;
      line_pix <= 1'b0;
    end else begin
      unique case (ev)
        EV_FRAME: begin
          col      <= '0;
          row      <= '0;
          hs_q     <= 1'b0;
          line_pix <= 1'b0;
        end
        EV_LINE: begin
          col      <= '0;
          hs_q     <= 1'b1;
          line_pix <= 1'b0;
          // Empty lines do not advance the row.
          if (!hs_q && line_pix && (row != '1))
            row <= row + RW'(1);
        end
        EV_PIX: begin
          hs_q     <= 1'b0;
          line_pix <= 1'b1;
          if (in_range)
            col <= col + CW'(1);
        end
        EV_IDLE: begin
          hs_q <= 1'b0;
        end
      endcase
    end
  end

  // Line buffers: RAM, never cleared; masking hides stale data.
  always_ff @(posedge clk) begin
    if (acc && in_range) begin
      lb2[addr] <= lb1_rd;
      lb1[addr] <= gray_data;
    end
  end

  // Stage 1: window shift.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          win[i][j] <= '0;
      s1 <= '0;
    end else begin
      s1.vld  <= acc;
      s1.mask <= mask_now;
      if (acc) begin
        for (int i = 0; i < 3; i++) begin
          win[i][0] <= win[i][1];
          win[i][1] <= win[i][2];
        end
        win[0][2] <= lb2_rd;
        win[1][2] <= lb1_rd;
        win[2][2] <= gray_data;
      end
    end
  end

  // Gradient halves are unsigned (max 1020), difference is 11-bit signed.
  assign gx_p = 10'(win[0][2]) +
                {1'b0, win[1][2], 1'b0} +
                10'(win[2][2]);
  assign gx_n = 10'(win[0][0]) +
                {1'b0, win[1][0], 1'b0} +
                10'(win[2][0]);
  assign gy_p = 10'(win[2][0]) +
                {1'b0, win[2][1], 1'b0} +
                10'(win[2][2]);
  assign gy_n = 10'(win[0][0]) +
                {1'b0, win[0][1], 1'b0} +
                10'(win[0][2]);

  assign gx = $signed({1'b0, gx_p}) -
              $signed({1'b0, gx_n});
  assign gy = $signed({1'b0, gy_p}) -
              $signed({1'b0, gy_n});

  // Stage 2: gradients.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      s2 <= '0;
    end else begin
      s2.vld  <= s1.vld;
      s2.mask <= s1.mask;
      s2.gx   <= gx;
      s2.gy   <= gy;
    end
  end

  function automatic logic [9:0] abs11(
    input logic signed [10:0] v
  );
    logic signed [10:0] n;
    n = -v;
    return v[10] ? n[9:0] : v[9:0];
  endfunction

  assign mag = {1'b0, abs11(s2.gx)} +
               {1'b0, abs11(s2.gy)};
  assign sat = (mag > SAT11) ? SAT8 : mag[7:0];

  // Stage 3: output; data holds while idle.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      sobel_valid <= 1'b0;
      sobel_data  <= '0;
    end else begin
      sobel_valid <= s2.vld;
      if (s2.vld)
        sobel_data <= s2.mask ? 8'd0 : sat;
    end
  end

endmodule

// File: tb/tb_sobel.sv
// tb_sobel: table-driven and randomized frames checked against a kernel model.
// Drives sobel with a narrow line width so line overflow is exercised.
`timescale 1ns/1ps
module tb_sobel;

  localparam int W = 10;
  localparam int KX [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
  localparam int KY [3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       gray_valid = 1'b0;
  logic [7:0] gray_data = 8'd0;
  logic       hsync = 1'b0;
  logic       vsync = 1'b1;
  logic       sobel_valid;
  logic [7:0] sobel_data;

  sobel #(.IMG_WIDTH(W), .SAT_MAX(255)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .gray_valid(gray_valid),
    .gray_data(gray_data),
    .hsync(hsync),
    .vsync(vsync),
    .sobel_valid(sobel_valid),
    .sobel_data(sobel_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;     // 0 flat, 1 vstep, 2 hramp, 3 vramp, 4 random
    int gap;      // 0 none, 1 toggle, 2 random
    bit rst_mid;
    int h;
    int w;
    int e_int;
    int e_step;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   exp_q[$];
  logic [2:0] hist = 3'b000;
  bit   mon_en = 1'b0;
  int   last_data = 0;
  int   n_out = 0;
  int   img [16][16];
  vec_t tbl [8];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: valid must trail accepts by three cycles, data from scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("valid_pattern", int'(sobel_valid), int'(hist[2]));
      if (sobel_valid && hist[2]) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0d expected none", sobel_data);
        end else begin
          chk("pixel", int'(sobel_data), exp_q.pop_front());
        end
      end else if (!sobel_valid) begin
        chk("hold", int'(sobel_data), last_data);
      end
      if (sobel_valid) begin
        last_data = int'(sobel_data);
        n_out++;
      end
      if (rst_n) begin
        hist = 3'b000;
        exp_q.delete();
        last_data = 0;
      end else begin
        hist = {hist[1:0], gray_valid && vsync && !hsync};
      end
    end
  end

  function automatic int ref_pix(int r, int c);
    int gx;
    int gy;
    int m;
    if (r < 2 || c < 2 || c >= W) return 0;
    gx = 0;
    gy = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        gx += KX[i][j] * img[r - 2 + i][c - 2 + j];
        gy += KY[i][j] * img[r - 2 + i][c - 2 + j];
      end
    m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (m > 255) ? 255 : m;
  endfunction

  task automatic drive(input logic v, input logic [7:0] d, input logic h,
                       input logic vs, input int e);
    gray_valid = v;
    gray_data  = d;
    hsync      = h;
    vsync      = vs;
    if (v && vs && !h && !rst_n) exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input vec_t t);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        case (t.kind)
          0: img[r][c] = 100;
          1: img[r][c] = (c < 4) ? 0 : 255;
          2: img[r][c] = 10 * c;
          3: img[r][c] = 5 * r;
          default: img[r][c] = int'($urandom_range(0, 255));
        endcase
  endtask

  task automatic reset_mid();
    drive(1'b0, 8'd0, 1'b1, 1'b0, 0);
    drive(1'b0, 8'd0, 1'b1, 1'b1, 0);
    for (int c = 0; c < 5; c++) drive(1'b1, 8'(40 * c), 1'b0, 1'b1, 0);
    drive(1'b0, 8'd0, 1'b1, 1'b1, 0);
    for (int c = 0; c < 3; c++) drive(1'b1, 8'(200 - c), 1'b0, 1'b1, 0);
    rst_n = 1'b1;
    drive(1'b1, 8'd9, 1'b0, 1'b1, 0);
    drive(1'b1, 8'd9, 1'b0, 1'b1, 0);
    rst_n = 1'b0;
  endtask

  task automatic run_frame(input vec_t t);
    int n0;
    int e;
    n0 = n_out;
    fill(t);
    // vsync with a coincident pixel: the pixel must be ignored.
    drive(1'b1, 8'h55, 1'b0, 1'b0, 0);
    for (int r = 0; r < t.h; r++) begin
      repeat (1 + $urandom_range(0, 2))
        drive(1'($urandom_range(0, 1)), 8'hAA, 1'b1, 1'b1, 0);
      for (int c = 0; c < t.w; c++) begin
        if (t.kind == 4)
          e = ref_pix(r, c);
        else if (r < 2 || c < 2)
          e = 0;
        else if (t.kind == 1 && (c == 4 || c == 5))
          e = t.e_step;
        else
          e = t.e_int;
        drive(1'b1, 8'(img[r][c]), 1'b0, 1'b1, e);
        if (t.gap == 1)
          drive(1'b0, 8'h00, 1'b0, 1'b1, 0);
        else if (t.gap == 2)
          while ($urandom_range(0, 3) == 0)
            drive(1'b0, 8'h11, 1'b0, 1'b1, 0);
      end
    end
    repeat (6) drive(1'b0, 8'd0, 1'b1, 1'b1, 0);
    chk("out_count", n_out - n0, t.h * t.w);
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   lat;
    vec_t rv;

    tbl[0] = '{kind: 0, gap: 0, rst_mid: 0, h: 8, w: 8, e_int: 0,  e_step: 0};
    tbl[1] = '{kind: 1, gap: 0, rst_mid: 0, h: 8, w: 8, e_int: 0,  e_step: 255};
    tbl[2] = '{kind: 2, gap: 0, rst_mid: 0, h: 8, w: 8, e_int: 80, e_step: 80};
    tbl[3] = '{kind: 3, gap: 0, rst_mid: 0, h: 8, w: 8, e_int: 40, e_step: 40};
    tbl[4] = '{kind: 0, gap: 1, rst_mid: 0, h: 8, w: 8, e_int: 0,  e_step: 0};
    tbl[5] = '{kind: 2, gap: 1, rst_mid: 1, h: 8, w: 8, e_int: 80, e_step: 80};
    tbl[6] = '{kind: 3, gap: 2, rst_mid: 1, h: 8, w: 8, e_int: 40, e_step: 40};
    tbl[7] = '{kind: 1, gap: 2, rst_mid: 0, h: 6, w: 8, e_int: 0,  e_step: 255};

    // Reset held with pixels offered.
    rst_n      = 1'b1;
    gray_valid = 1'b1;
    gray_data  = 8'd123;
    hsync      = 1'b0;
    vsync      = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      chk("rst_valid", int'(sobel_valid), 0);
      chk("rst_data", int'(sobel_data), 0);
    end
    rst_n = 1'b0;

    // First accept after release: output three edges later.
    drive(1'b1, 8'd77, 1'b0, 1'b1, 0);
    gray_valid = 1'b0;
    lat = 1;
    while (!sobel_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("first_latency", lat, 3);
    repeat (3) drive(1'b0, 8'd0, 1'b1, 1'b1, 0);

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].rst_mid) reset_mid();
      run_frame(tbl[i]);
    end

    for (int k = 0; k < 6; k++) begin
      rv.kind    = 4;
      rv.gap     = 2;
      rv.rst_mid = 0;
      rv.h       = int'($urandom_range(3, 7));
      rv.w       = int'($urandom_range(3, 12));
      rv.e_int   = 0;
      rv.e_step  = 0;
      run_frame(rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
